// File: rtl/dmem_wait_responder.sv
// Data-memory responder with req/ready handshake and fixed programmable latency.
// Byte-addressed big-endian storage; bit 0 is the MSB of every bus.
module dmem_wait_responder #(
    parameter int unsigned SIZE    = 16384,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic [0:31] addr,
    input  logic [0:31] data_in,
    input  logic        write_enable,
    // "byte" is a reserved word in SystemVerilog, so the byte-access strobe is byte_en.
    input  logic        byte_en,
    input  logic        half_word,
    input  logic        sign_extend,
    output logic        ready,
    output logic [0:31] data_out,
    output logic        error
);

    localparam int unsigned AW       = $clog2(SIZE);
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    logic [0:7] mem [0:SIZE-1];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [0:31] addr_q, addr_d;
    logic [0:31] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        byte_q, byte_d;
    logic        half_q, half_d;
    logic        sext_q, sext_d;
    logic        ready_q, ready_d;
    logic [0:31] dout_q, dout_d;
    logic        err_q, err_d;

    logic [AW-1:0] ea0, ea1, ea2, ea3;
    logic [0:7]    rb0, rb1, rb2, rb3;
    logic [0:7]    wd0, wd1, wd2, wd3;
    logic [0:3]    lane_we;
    logic          misalign;
    logic          exec;
    logic [0:31]   load_val;

    always_comb begin
        ea0 = addr_q[32-AW:31];
        ea1 = ea0 + AW'(1);
        ea2 = ea0 + AW'(2);
        ea3 = ea0 + AW'(3);
        rb0 = mem[ea0];
        rb1 = mem[ea1];
        rb2 = mem[ea2];
        rb3 = mem[ea3];
    end

    always_comb begin
        misalign = 1'b0;
        if (byte_q) begin
            misalign = 1'b0;
        end else if (half_q) begin
            misalign = addr_q[31];
        end else begin
            misalign = addr_q[30] | addr_q[31];
        end
    end

    always_comb begin
        load_val = '0;
        if (byte_q) begin
            load_val = {{24{sext_q & rb0[0]}}, rb0};
        end else if (half_q) begin
            load_val = {{16{sext_q & rb0[0]}}, rb0, rb1};
        end else begin
            load_val = {rb0, rb1, rb2, rb3};
        end
    end

    assign exec = (state_q == S_WAIT) && (cnt_q == 4'd0);

    // Reset at the execution edge must block the commit, so reset gates the lane enables.
    always_comb begin
        lane_we = '0;
        wd0     = '0;
        wd1     = '0;
        wd2     = '0;
        wd3     = '0;
        if (exec && we_q && !misalign && !reset) begin
            if (byte_q) begin
                lane_we = 4'b1000;
                wd0     = wdata_q[24:31];
            end else if (half_q) begin
                lane_we = 4'b1100;
                wd0     = wdata_q[16:23];
                wd1     = wdata_q[24:31];
            end else begin
                lane_we = 4'b1111;
                wd0     = wdata_q[0:7];
                wd1     = wdata_q[8:15];
                wd2     = wdata_q[16:23];
                wd3     = wdata_q[24:31];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (lane_we[0]) mem[ea0] <= wd0;
        if (lane_we[1]) mem[ea1] <= wd1;
        if (lane_we[2]) mem[ea2] <= wd2;
        if (lane_we[3]) mem[ea3] <= wd3;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        byte_d  = byte_q;
        half_d  = half_q;
        sext_d  = sext_q;
        ready_d = 1'b0;
        dout_d  = '0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    wdata_d = data_in;
                    we_d    = write_enable;
                    byte_d  = byte_en;
                    half_d  = half_word;
                    sext_d  = sign_extend;
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    ready_d = 1'b1;
                    err_d   = misalign;
                    dout_d  = (misalign || we_q) ? '0 : load_val;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            half_q  <= 1'b0;
            sext_q  <= 1'b0;
            ready_q <= 1'b0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            half_q  <= half_d;
            sext_q  <= sext_d;
            ready_q <= ready_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

    assign ready    = ready_q;
    assign data_out = dout_q;
    assign error    = err_q;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a byte-array reference model.
module tb_dmem_wait_responder;

    logic        clock = 1'b0;
    logic        reset, req, req1;
    logic [0:31] addr, data_in;
    logic        write_enable, byte_en, half_word, sign_extend;
    logic        ready, error, ready1, error1;
    logic [0:31] data_out, data_out1;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    dmem_wait_responder #(.SIZE(16384), .LATENCY(2)) dut (
        .clock(clock), .reset(reset), .req(req), .addr(addr), .data_in(data_in),
        .write_enable(write_enable), .byte_en(byte_en), .half_word(half_word),
        .sign_extend(sign_extend), .ready(ready), .data_out(data_out), .error(error)
    );

    dmem_wait_responder #(.SIZE(16384), .LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .req(req1), .addr(addr), .data_in(data_in),
        .write_enable(write_enable), .byte_en(byte_en), .half_word(half_word),
        .sign_extend(sign_extend), .ready(ready1), .data_out(data_out1), .error(error1)
    );

    typedef struct {
        string       name;
        bit          we;
        logic [31:0] a;
        logic [31:0] d;
        bit          b;
        bit          h;
        bit          s;
        logic [31:0] exp_d;
        bit          exp_e;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] mref [0:16383];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input string nm, input bit we, input logic [31:0] a, d,
                                input bit b, h, s, input logic [31:0] ed, input bit ee);
        vec_t v;
        v.name = nm; v.we = we; v.a = a; v.d = d; v.b = b; v.h = h; v.s = s;
        v.exp_d = ed; v.exp_e = ee;
        vecs.push_back(v);
    endfunction

    // Reference: size in bytes, alignment by modulo, big-endian byte loops.
    function automatic void model_access(input bit we, input logic [31:0] a, d, input bit b, h, s,
                                         output logic [31:0] dout, output bit err);
        int unsigned ea, n;
        logic [31:0] v;
        ea   = a % 16384;
        n    = b ? 1 : (h ? 2 : 4);
        err  = (ea % n) != 0;
        dout = 32'h0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < int'(n); i++)
                mref[ea + i] = 8'(d >> (8 * (int'(n) - 1 - i)));
        end else begin
            v = 32'h0;
            for (int i = 0; i < int'(n); i++)
                v = (v << 8) | {24'h0, mref[ea + i]};
            if (s && n < 4 && v[8 * n - 1])
                v = v | ~((32'd1 << (8 * n)) - 32'd1);
            dout = v;
        end
    endfunction

    task automatic drive(input bit we, input logic [31:0] a, d, input bit b, h, s);
        write_enable = we; addr = a; data_in = d;
        byte_en = b; half_word = h; sign_extend = s;
    endtask

    // Called just after an edge with the DUT idle; returns edges from acceptance to ready.
    task automatic run_txn(input bit we, input logic [31:0] a, d, input bit b, h, s,
                           input bit junk, output int lat, output logic [31:0] dout,
                           output logic err);
        drive(we, a, d, b, h, s);
        req = 1'b1;
        @(posedge clock); #1;
        req  = 1'b0;
        lat  = -1;
        dout = 32'h0;
        err  = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (junk) begin
                req = 1'($urandom);
                drive(1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
            end
            @(posedge clock); #1;
            if (ready) begin
                lat  = n;
                dout = data_out;
                err  = error;
                break;
            end
        end
        req = junk ? 1'($urandom) : 1'b0;
        @(posedge clock); #1;
        req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [31:0] dout, exp_d;
        logic        err;
        bit          exp_e;
        bit          we, b, h, s;
        logic [31:0] a, d;

        reset = 1'b1; req = 1'b0; req1 = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", {31'h0, ready}, 32'h0);
        check("rst_dout", data_out, 32'h0);
        check("rst_error", {31'h0, error}, 32'h0);
        check("rst_ready_l1", {31'h0, ready1}, 32'h0);
        check("rst_dout_l1", data_out1, 32'h0);
        reset = 1'b0;

        // Word store with handshake timing, then a req held across DONE and IDLE.
        drive(1, 32'h100, 32'hDEADBEEF, 0, 0, 0); req = 1'b1;
        @(posedge clock); #1; req = 1'b0;
        @(posedge clock); #1; check("s1_ready_e1", {31'h0, ready}, 32'h0);
        @(posedge clock); #1; check("s1_ready_e2", {31'h0, ready}, 32'h1);
        check("s1_err", {31'h0, error}, 32'h0);
        check("s1_dout", data_out, 32'h0);
        check("s1_mem", {dut.mem[256], dut.mem[257], dut.mem[258], dut.mem[259]}, 32'hDEADBEEF);
        drive(0, 32'h100, 32'h0, 0, 0, 0); req = 1'b1;
        @(posedge clock); #1; check("s1_ready_e3", {31'h0, ready}, 32'h0);
        @(posedge clock); #1; req = 1'b0;
        @(posedge clock); #1; check("s1_ready_e5", {31'h0, ready}, 32'h0);
        @(posedge clock); #1; check("s1_ready_e6", {31'h0, ready}, 32'h1);
        check("s1_load", data_out, 32'hDEADBEEF);
        @(posedge clock); #1;

        add("ldb_101_sx",  0, 32'h101,  32'h0,        1, 0, 1, 32'hFFFFFFAD, 0);
        add("ldb_103",     0, 32'h103,  32'h0,        1, 0, 0, 32'h000000EF, 0);
        add("ldh_102_sx",  0, 32'h102,  32'h0,        0, 1, 1, 32'hFFFFBEEF, 0);
        add("ldh_100",     0, 32'h100,  32'h0,        0, 1, 0, 32'h0000DEAD, 0);
        add("stb_100",     1, 32'h100,  32'hAAAAAA12, 1, 0, 0, 32'h0,        0);
        add("ldw_100_a",   0, 32'h100,  32'h0,        0, 0, 0, 32'h12ADBEEF, 0);
        add("ldbh_103_sx", 0, 32'h103,  32'h0,        1, 1, 1, 32'hFFFFFFEF, 0);
        add("stw_200",     1, 32'h200,  32'h01020304, 0, 0, 0, 32'h0,        0);
        add("stbh_201",    1, 32'h201,  32'h00001234, 1, 1, 0, 32'h0,        0);
        add("ldw_200",     0, 32'h200,  32'h0,        0, 0, 0, 32'h01340304, 0);
        add("stw_102_mis", 1, 32'h102,  32'h11111111, 0, 0, 0, 32'h0,        1);
        add("ldw_100_b",   0, 32'h100,  32'h0,        0, 0, 0, 32'h12ADBEEF, 0);
        add("ldh_101_mis", 0, 32'h101,  32'h0,        0, 1, 1, 32'h0,        1);
        add("ldw_4100",    0, 32'h4100, 32'h0,        0, 0, 1, 32'h12ADBEEF, 0);
        add("ldw_201_mis", 0, 32'h201,  32'h0,        0, 0, 0, 32'h0,        1);
        add("ldh_202_sx",  0, 32'h202,  32'h0,        0, 1, 1, 32'h00000304, 0);
        add("stw_204",     1, 32'h204,  32'h80000001, 0, 0, 0, 32'h0,        0);
        add("ldw_204_sx",  0, 32'h204,  32'h0,        0, 0, 1, 32'h80000001, 0);
        add("ldb_204",     0, 32'h204,  32'h0,        1, 0, 0, 32'h00000080, 0);
        add("ldh_204_sx",  0, 32'h204,  32'h0,        0, 1, 1, 32'hFFFF8000, 0);

        foreach (vecs[i]) begin
            run_txn(vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].b, vecs[i].h, vecs[i].s, 0, lat, dout, err);
            check({vecs[i].name, "_lat"}, lat, 32'd2);
            check({vecs[i].name, "_dout"}, dout, vecs[i].exp_d);
            check({vecs[i].name, "_err"}, {31'h0, err}, {31'h0, vecs[i].exp_e});
        end

        // Reset one edge after acceptance aborts the store.
        drive(1, 32'h100, 32'h11223344, 0, 0, 0); req = 1'b1;
        @(posedge clock); #1; req = 1'b0; reset = 1'b1;
        @(posedge clock); #1; reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            check("abort_no_ready", {31'h0, ready}, 32'h0);
            @(posedge clock); #1;
        end
        run_txn(0, 32'h100, 32'h0, 0, 0, 0, 0, lat, dout, err);
        check("abort_load", dout, 32'h12ADBEEF);

        // Reset coinciding with the execution edge blocks the commit.
        drive(1, 32'h100, 32'h55667788, 0, 0, 0); req = 1'b1;
        @(posedge clock); #1; req = 1'b0;
        @(posedge clock); #1; reset = 1'b1;
        @(posedge clock); #1; reset = 1'b0;
        check("exec_rst_ready", {31'h0, ready}, 32'h0);
        @(posedge clock); #1;
        check("exec_rst_ready2", {31'h0, ready}, 32'h0);
        run_txn(0, 32'h100, 32'h0, 0, 0, 0, 0, lat, dout, err);
        check("exec_rst_load", dout, 32'h12ADBEEF);

        // LATENCY=1 instance: ready one edge after acceptance.
        drive(1, 32'h100, 32'hDEADBEEF, 0, 0, 0); req1 = 1'b1;
        @(posedge clock); #1; req1 = 1'b0;
        @(posedge clock); #1; check("l1_ready_e1", {31'h0, ready1}, 32'h1);
        check("l1_err", {31'h0, error1}, 32'h0);
        check("l1_mem", {dut1.mem[256], dut1.mem[257], dut1.mem[258], dut1.mem[259]}, 32'hDEADBEEF);
        drive(0, 32'h100, 32'h0, 0, 0, 0); req1 = 1'b1;
        @(posedge clock); #1; check("l1_ready_e2", {31'h0, ready1}, 32'h0);
        @(posedge clock); #1; req1 = 1'b0;
        check("l1_ready_e3", {31'h0, ready1}, 32'h0);
        @(posedge clock); #1; check("l1_ready_e4", {31'h0, ready1}, 32'h1);
        check("l1_load", data_out1, 32'hDEADBEEF);
        @(posedge clock); #1;

        // Random traffic in a 64-byte window with random alias bits.
        for (int w = 0; w < 16; w++) begin
            d = $urandom;
            model_access(1, 32'h300 + 32'(4 * w), d, 0, 0, 0, exp_d, exp_e);
            run_txn(1, 32'h300 + 32'(4 * w), d, 0, 0, 0, 0, lat, dout, err);
        end
        for (int t = 0; t < 300; t++) begin
            we = ($urandom_range(0, 2) == 0);
            b  = 1'($urandom); h = 1'($urandom); s = 1'($urandom);
            a  = ($urandom & 32'hFFFFC000) | (32'h300 + 32'($urandom_range(0, 63)));
            d  = $urandom;
            model_access(we, a, d, b, h, s, exp_d, exp_e);
            run_txn(we, a, d, b, h, s, 1, lat, dout, err);
            check("rnd_lat", lat, 32'd2);
            check("rnd_dout", dout, exp_d);
            check("rnd_err", {31'h0, err}, {31'h0, exp_e});
        end
        for (int i = 12'h300; i < 12'h340; i++)
            check("rnd_mem", {24'h0, dut.mem[i]}, {24'h0, mref[i]});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
